// File: rtl/rect_draw_engine.sv
// Rectangle/sprite raster engine: sweeps an x/y counter pair over a commanded
// rectangle and streams one clipped, optionally ROM-sourced pixel per clock.
module rect_draw_engine #(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOR_W     = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int ADDR_W      = 14,
  parameter int BG_COLOR    = 0,
  parameter int TRANSPARENT = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [X_W-1:0]     w_in,
  input  logic [Y_W-1:0]     h_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               abort,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               busy,
  output logic [X_W-1:0]     xout,
  output logic [Y_W-1:0]     yout,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               done
);

  typedef enum logic {IDLE, DRAW} state_t;

  localparam logic [1:0]         M_ERASE  = 2'd1;
  localparam logic [1:0]         M_SPRITE = 2'd2;
  localparam logic [X_W:0]       SCR_W    = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]       SCR_H    = (Y_W+1)'(SCREEN_H);
  localparam logic [COLOR_W-1:0] BG       = COLOR_W'(BG_COLOR);
  localparam logic [COLOR_W-1:0] TRANSP   = COLOR_W'(TRANSPARENT);
  localparam logic [X_W-1:0]     X_ONE    = X_W'(1);
  localparam logic [Y_W-1:0]     Y_ONE    = Y_W'(1);

  state_t state, state_nxt;

  logic [X_W-1:0]     x_q, w_q, xcnt;
  logic [Y_W-1:0]     y_q, h_q, ycnt;
  logic [1:0]         mode_q;
  logic [COLOR_W-1:0] color_q;
  logic [X_W:0]       xs;
  logic [Y_W:0]       ys;
  logic               row_end, last, zero_size, plot_q;

  function automatic logic [COLOR_W-1:0] pick_color(input logic [1:0]         m,
                                                     input logic [COLOR_W-1:0] fill,
                                                     input logic [COLOR_W-1:0] rom);
    case (m)
      M_ERASE:  return BG;
      M_SPRITE: return rom;
      default:  return fill;
    endcase
  endfunction

  assign row_end   = (xcnt == w_q - X_ONE);
  assign last      = row_end && (ycnt == h_q - Y_ONE);
  assign zero_size = (w_in == '0) || (h_in == '0);
  assign xs        = {1'b0, x_q} + {1'b0, xcnt};
  assign ys        = {1'b0, y_q} + {1'b0, ycnt};
  assign busy      = (state == DRAW);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !zero_size) state_nxt = DRAW;
      DRAW: if (abort || last)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch and sweep counters (DRAW cycle, stage p0)
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      mode_q   <= '0;
      color_q  <= '0;
      xcnt     <= '0;
      ycnt     <= '0;
      rom_addr <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        x_q      <= x_in;
        y_q      <= y_in;
        w_q      <= w_in;
        h_q      <= h_in;
        mode_q   <= mode;
        color_q  <= color_in;
        xcnt     <= '0;
        ycnt     <= '0;
        rom_addr <= '0;
      end
    end else begin
      if (row_end) begin
        xcnt <= '0;
        ycnt <= ycnt + Y_ONE;
      end else begin
        xcnt <= xcnt + X_ONE;
      end
      rom_addr <= rom_addr + ADDR_W'(1);
    end
  end

  // Output stage (p1): coordinates, clip-qualified plot and completion pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      xout   <= '0;
      yout   <= '0;
      plot_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      xout   <= xs[X_W-1:0];
      yout   <= ys[Y_W-1:0];
      plot_q <= (state == DRAW) && !abort && (xs < SCR_W) && (ys < SCR_H);
      done   <= ((state == IDLE) && start && zero_size) ||
                ((state == DRAW) && !abort && last);
    end
  end

  // rom_data arrives with the output cycle, so the sprite colour and its
  // transparency test are taken combinationally here.
  assign color = pick_color(mode_q, color_q, rom_data);
  assign plot  = plot_q && ((mode_q != M_SPRITE) || (rom_data != TRANSP));

endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: fill, clipping, sprite transparency,
// zero size, abort, back-to-back and mid-draw reset.
module tb_rect_draw_engine;

  logic        clock = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  mode;
  logic [7:0]  x_in, w_in, xout;
  logic [6:0]  y_in, h_in, yout;
  logic [2:0]  color_in, color;
  logic [2:0]  rom_data = 3'd0;
  logic [13:0] rom_addr;
  logic        busy, plot, done;
  logic [2:0]  rom [0:3];

  int nchk, nerr;

  rect_draw_engine dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in),
    .color_in(color_in), .abort(abort), .rom_data(rom_data),
    .rom_addr(rom_addr), .busy(busy), .xout(xout), .yout(yout),
    .color(color), .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    rom_data <= (rom_addr < 14'd4) ? rom[rom_addr[1:0]] : 3'd0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] m, input int x, input int y,
                       input int w, input int h, input int c);
    mode     = m;
    x_in     = 8'(x);
    y_in     = 7'(y);
    w_in     = 8'(w);
    h_in     = 7'(h);
    color_in = 3'(c);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_xout"}, xout, 0);
    chk({tag, "_yout"}, yout, 0);
    chk({tag, "_color"}, color, 0);
    chk({tag, "_plot"}, plot, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_romaddr"}, rom_addr, 0);
  endtask

  initial begin
    nchk = 0; nerr = 0;
    rom[0] = 3'd1; rom[1] = 3'd5; rom[2] = 3'd5; rom[3] = 3'd2;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    x_in = '0; y_in = '0; w_in = '0; h_in = '0; color_in = '0;
    repeat (2) @(negedge clock);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clock);

    // FILL 4x2 at (10,20) colour 4
    issue(2'd0, 10, 20, 4, 2, 4);
    chk("fill_busy_first", busy, 1);
    chk("fill_plot_first", plot, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("fill_x", xout, 10 + k % 4);
      chk("fill_y", yout, 20 + k / 4);
      chk("fill_plot", plot, 1);
      chk("fill_color", color, 4);
      chk("fill_done", done, (k == 7) ? 1 : 0);
      chk("fill_busy", busy, (k < 7) ? 1 : 0);
    end

    // Clipping, issued back-to-back in the done cycle
    issue(2'd0, 158, 0, 4, 1, 3);
    chk("b2b_busy", busy, 1);
    chk("b2b_gap_plot", plot, 0);
    chk("b2b_gap_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("clip_x", xout, 158 + k);
      chk("clip_plot", plot, (k < 2) ? 1 : 0);
      chk("clip_done", done, (k == 3) ? 1 : 0);
      if (k < 2) chk("clip_color", color, 3);
    end
    @(negedge clock);

    // SPRITE 2x2 at (50,30), ROM {1,5,5,2}
    issue(2'd2, 50, 30, 2, 2, 1);
    chk("spr_romaddr0", rom_addr, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k < 3) chk("spr_romaddr", rom_addr, k + 1);
      chk("spr_x", xout, 50 + k % 2);
      chk("spr_y", yout, 30 + k / 2);
      chk("spr_plot", plot, (k == 0 || k == 3) ? 1 : 0);
      if (k == 0) chk("spr_color0", color, 1);
      if (k == 3) chk("spr_color3", color, 2);
      chk("spr_done", done, (k == 3) ? 1 : 0);
    end
    @(negedge clock);

    // Zero width
    issue(2'd0, 20, 20, 0, 3, 7);
    chk("zero_done", done, 1);
    chk("zero_plot", plot, 0);
    chk("zero_busy", busy, 0);
    @(negedge clock);
    chk("zero_done_after", done, 0);
    chk("zero_plot_after", plot, 0);
    chk("zero_busy_after", busy, 0);

    // Abort in the 3rd DRAW cycle of a 5x5 FILL
    issue(2'd0, 0, 0, 5, 5, 6);
    chk("abt_busy", busy, 1);
    @(negedge clock);
    chk("abt_plot_p0", plot, 1);
    @(negedge clock);
    chk("abt_plot_p1", plot, 1);
    chk("abt_x_p1", xout, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abt_plot_after", plot, 0);
    chk("abt_busy_after", busy, 0);
    chk("abt_done_after", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("abt_no_done", done, 0);
      chk("abt_no_plot", plot, 0);
    end

    // Start with abort in IDLE: start wins
    abort = 1'b1;
    issue(2'd0, 5, 6, 1, 1, 7);
    abort = 1'b0;
    chk("sa_busy", busy, 1);
    @(negedge clock);
    chk("sa_plot", plot, 1);
    chk("sa_x", xout, 5);
    chk("sa_y", yout, 6);
    chk("sa_color", color, 7);
    chk("sa_done", done, 1);
    chk("sa_busy_end", busy, 0);
    @(negedge clock);

    // Reset mid-draw, then ERASE 1x1
    issue(2'd0, 1, 1, 3, 3, 2);
    @(negedge clock);
    chk("mid_plot", plot, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_all_zero("midrst");
    @(negedge clock);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_plot", plot, 0);
    issue(2'd1, 7, 9, 1, 1, 6);
    chk("ers_busy", busy, 1);
    @(negedge clock);
    chk("ers_plot", plot, 1);
    chk("ers_color", color, 0);
    chk("ers_x", xout, 7);
    chk("ers_y", yout, 9);
    chk("ers_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/rect_draw_engine.md
# rect_draw_engine

Parametrised rectangle/sprite raster engine for the VGA game datapath. It replaces the fixed background, car and erase drawing paths with one engine. A control FSM issues a draw command (origin, size, mode, colour). The engine sweeps an x/y counter pair and streams one pixel per clock to the VGA adapter port, with screen clipping, sprite ROM fetch, transparency, and a done pulse for the controlling FSM.

## Interface
- X_W, 8, x coordinate / width bits
- Y_W, 7, y coordinate / height bits
- COLOR_W, 3, colour bits
- SCREEN_W, 160, visible columns; x ≥ SCREEN_W is clipped
- SCREEN_H, 120, visible rows; y ≥ SCREEN_H is clipped
- ADDR_W, 14, sprite ROM address bits
- BG_COLOR, 0, colour used by ERASE mode
- TRANSPARENT, 5, sprite colour that is never plotted
---
- clock  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- mode  in  2  0 FILL, 1 ERASE, 2 SPRITE, 3 treated as FILL
- x_in / y_in  in  X_W / Y_W  rectangle origin
- w_in / h_in  in  X_W / Y_W  rectangle size in pixels
- color_in  in  COLOR_W  fill colour
- abort  in  1  cancel the current command
- rom_data  in  COLOR_W  sprite ROM data; 1-cycle registered-read latency
- rom_addr  out  ADDR_W  sprite ROM address
- busy  out  1  high while in DRAW
- xout / yout  out  X_W / Y_W  pixel coordinate
- color  out  COLOR_W  pixel colour
- plot  out  1  write-enable to the VGA adapter
- done  out  1  one-cycle completion pulse

## Operation
- FSM has two states: IDLE and DRAW.
- IDLE, start=1:
  - Latch x_in, y_in, w_in, h_in, mode and color_in.
  - Clear xcounter, ycounter and rom_addr to 0.
  - If w_in=0 or h_in=0: stay in IDLE. done=1 in the next cycle; no plot.
  - Otherwise go to DRAW.
- DRAW, each cycle:
  - If xcounter = w−1: xcounter←0 and ycounter←ycounter+1.
  - Otherwise: xcounter←xcounter+1.
  - rom_addr←rom_addr+1, wrapping at 2^ADDR_W.
  - At xcounter=w−1 and ycounter=h−1 (last pixel): go to IDLE.
- Output stage, registered from the DRAW cycle's counters:
  - xs = x_q+xcounter, computed X_W+1 bits wide.
  - ys = y_q+ycounter, computed Y_W+1 bits wide.
  - Register xout=xs[X_W−1:0] and yout=ys[Y_W−1:0].
  - plot_q = in DRAW AND xs<SCREEN_W AND ys<SCREEN_H. Carry-out counts as clipped.
  - Register done = the last pixel was issued.
- Colour selection (uses mode_q):
  - FILL: color = latched color_in.
  - ERASE: color = BG_COLOR.
  - SPRITE: color = rom_data, taken combinationally in the output cycle. plot = plot_q AND rom_data≠TRANSPARENT.
  - In all other modes plot = plot_q.
- Clipped and transparent pixels still take their cycle. done timing is independent of clipping and transparency.
- start while busy: ignored.
- abort in DRAW:
  - Go to IDLE at the next edge and clear plot_q.
  - done is not asserted.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Sprite ROM is row-major, w pixels per row, with the sprite's first pixel at address 0.

## Timing
- Reset: state=IDLE. xout, yout, color, plot, done, busy, rom_addr and the counters are all 0.
- Command accepted at edge E0: pixel k (k=0..W·H−1) is on the outputs during the cycle after edge E(k+1).
- Throughput: one pixel per clock; total W·H+1 cycles from start to done.
- done is high in the same cycle as the last pixel's plot.
- busy falls at the same edge that launches the last pixel.
- Back-to-back: a start asserted in the done cycle is accepted. The first pixel of the new command follows two cycles later, with no overlap.
- rom_addr is valid during the DRAW cycle. The ROM registers it, so rom_data aligns with the output cycle.
- Reset mid-DRAW: IDLE next cycle, all outputs 0, no done.

## Test plan
- FILL x=10, y=20, w=4, h=2, color 4:
  - 8 consecutive plots, (10..13,20) then (10..13,21), all with color 4.
  - done on the 8th plot; busy high for 8 cycles.
- Clipping, x=158, w=4, y=0, h=1:
  - Plots at x=158 and x=159 only.
  - Cycles 3 and 4 have plot=0; done at cycle 4.
- SPRITE 2×2 with ROM {1,5,5,2} and TRANSPARENT=5:
  - rom_addr goes 0,1,2,3.
  - Plots (x,y) colour 1 and (x+1,y+1) colour 2; done on the 4th cycle.
- Zero size (w=0):
  - done exactly one cycle after start; plot never asserted; busy stays 0.
- abort in the 3rd DRAW cycle of a 5×5 FILL:
  - plot=0 from the next cycle; no done.
  - A following start in IDLE is accepted.
- reset mid-draw, then ERASE 1×1:
  - All outputs 0 after reset.
  - The ERASE plots once with BG_COLOR and done.
